branch_predictor_btb: RTL and testbench

Parametrised next-generation fetch-stage predictor: 2-bit saturating-counter PHT in bimodal or gshare mode, plus a tagged direct-mapped BTB that supplies real targets. It predicts combinationally from the fetch PC and trains from a separate commit-side update port indexed by the branch's own PC. After reset, an init sweep clears both tables so that large tables do not need a reset fan-out.

---
 rtl/branch_predictor_btb_if.sv | 34 +++
 rtl/branch_predictor_btb.sv | 231 +++++++++++++++++++++++
 tb/tb_branch_predictor_btb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_btb_if
// Bus between the fetch/commit pipeline and the branch predictor.
//   pc          : fetch PC to predict                      (master -> slave)
//   pred_taken  : predicted taken                          (slave  -> master)
//   pred_target : predicted next PC                        (slave  -> master)
//   pred_hit    : BTB hit for pc                           (slave  -> master)
//   ready       : init sweep finished, predictor live      (slave  -> master)
//   upd_valid   : resolved-branch update strobe            (master -> slave)
//   upd_pc      : PC of the resolved branch                (master -> slave)
//   upd_taken   : resolved direction                       (master -> slave)
//   upd_target  : resolved taken target                    (master -> slave)
// -----------------------------------------------------------------------------
interface branch_predictor_btb_if;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        pred_hit;
   logic        ready;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;

   modport master (
      output pc, upd_valid, upd_pc, upd_taken, upd_target,
      input  pred_taken, pred_target, pred_hit, ready
   );

   modport slave (
      input  pc, upd_valid, upd_pc, upd_taken, upd_target,
      output pred_taken, pred_target, pred_hit, ready
   );
endinterface

// File: rtl/branch_predictor_btb.sv
// -----------------------------------------------------------------------------
// branch_predictor_btb
// Fetch-stage predictor: 2-bit saturating-counter PHT (bimodal when
// GHR_BITS = 0, gshare otherwise) plus a tagged direct-mapped BTB.
// Prediction is combinational from bus.pc; training comes from the commit-side
// update port, indexed by the resolved branch's own PC.
// After reset an init sweep rewrites every table entry, so the tables carry no
// reset fan-out; ready rises once the sweep has covered the larger table.
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : branch_predictor_btb_if.slave (prediction + update signals)
// Parameters: PHT_IDX_BITS, BTB_IDX_BITS, TAG_BITS (BTB_IDX_BITS+TAG_BITS must
// not exceed 30), GHR_BITS (0..PHT_IDX_BITS), CTR_INIT.
// -----------------------------------------------------------------------------
module branch_predictor_btb #(
   parameter int unsigned PHT_IDX_BITS = 7,
   parameter int unsigned BTB_IDX_BITS = 6,
   parameter int unsigned TAG_BITS     = 8,
   parameter int unsigned GHR_BITS     = 0,
   parameter logic [1:0]  CTR_INIT     = 2'b01
) (
   input logic                  clk,
   input logic                  rst,
   branch_predictor_btb_if.slave bus
);

   localparam int unsigned PHT_DEPTH  = 32'd1 << PHT_IDX_BITS;
   localparam int unsigned BTB_DEPTH  = 32'd1 << BTB_IDX_BITS;
   localparam int unsigned INIT_BITS  = (PHT_IDX_BITS > BTB_IDX_BITS) ? PHT_IDX_BITS : BTB_IDX_BITS;
   localparam int unsigned INIT_LAST  = ((PHT_DEPTH > BTB_DEPTH) ? PHT_DEPTH : BTB_DEPTH) - 32'd1;
   localparam int unsigned CMP_BITS   = INIT_BITS + 32'd1;
   // A one-bit history register stands in for the absent history in bimodal mode.
   localparam int unsigned GHR_W      = (GHR_BITS == 0) ? 32'd1 : GHR_BITS;
   localparam int unsigned TAG_LO     = BTB_IDX_BITS + 32'd2;
   localparam int unsigned TAG_HI     = BTB_IDX_BITS + TAG_BITS + 32'd1;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Saturating 2-bit counter step.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      case ({taken, ctr})
         3'b1_11: nxt = 2'b11;
         3'b0_00: nxt = 2'b00;
         3'b1_00, 3'b1_01, 3'b1_10: nxt = ctr + 2'd1;
         3'b0_01, 3'b0_10, 3'b0_11: nxt = ctr - 2'd1;
         default: nxt = ctr;
      endcase
      return nxt;
   endfunction

   // Tables: no reset, cleared by the init sweep.
   logic [1:0]          pht_r        [PHT_DEPTH];
   logic                btb_valid_r  [BTB_DEPTH];
   logic [TAG_BITS-1:0] btb_tag_r    [BTB_DEPTH];
   logic [31:0]         btb_target_r [BTB_DEPTH];

   state_t                state_r;
   state_t                state_next_s;
   logic [INIT_BITS-1:0]  init_idx_r;
   logic [GHR_W-1:0]      ghr_r;
   logic [GHR_W-1:0]      ghr_next_s;
   logic                  ready_r;

   logic [PHT_IDX_BITS-1:0] ghr_ext_s;
   logic [PHT_IDX_BITS-1:0] pht_idx_s;
   logic [BTB_IDX_BITS-1:0] btb_idx_s;
   logic [TAG_BITS-1:0]     tag_s;
   logic                    hit_s;
   logic                    taken_s;
   logic [31:0]             target_s;

   logic [PHT_IDX_BITS-1:0] upd_pht_idx_s;
   logic [BTB_IDX_BITS-1:0] upd_btb_idx_s;
   logic [TAG_BITS-1:0]     upd_tag_s;
   logic                    pht_init_range_s;
   logic                    btb_init_range_s;

   logic                    pht_we_s;
   logic [PHT_IDX_BITS-1:0] pht_waddr_s;
   logic [1:0]              pht_wdata_s;
   logic                    btb_we_s;
   logic [BTB_IDX_BITS-1:0] btb_waddr_s;
   logic                    btb_wvalid_s;
   logic [TAG_BITS-1:0]     btb_wtag_s;
   logic [31:0]             btb_wtarget_s;

   // History alignment, index/tag derivation and next history value.
   always_comb begin
      ghr_ext_s = '0;
      ghr_ext_s[GHR_W-1:0] = ghr_r;   // ghr_r stays zero in bimodal mode
      pht_idx_s     = bus.pc[PHT_IDX_BITS+1:2] ^ ghr_ext_s;
      btb_idx_s     = bus.pc[BTB_IDX_BITS+1:2];
      tag_s         = bus.pc[TAG_HI:TAG_LO];
      upd_pht_idx_s = bus.upd_pc[PHT_IDX_BITS+1:2] ^ ghr_ext_s;
      upd_btb_idx_s = bus.upd_pc[BTB_IDX_BITS+1:2];
      upd_tag_s     = bus.upd_pc[TAG_HI:TAG_LO];
      // Shift-in works for every width; a 1-bit history simply becomes upd_taken.
      if (GHR_BITS == 0) begin
         ghr_next_s = '0;
      end else begin
         ghr_next_s = (ghr_r << 1) | GHR_W'(bus.upd_taken);
      end
      pht_init_range_s = ({1'b0, init_idx_r} < CMP_BITS'(PHT_DEPTH));
      btb_init_range_s = ({1'b0, init_idx_r} < CMP_BITS'(BTB_DEPTH));
   end

   // Combinational prediction; ready gates everything so INIT never predicts.
   always_comb begin
      if (ready_r && btb_valid_r[btb_idx_s] && (btb_tag_r[btb_idx_s] == tag_s)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
      taken_s = hit_s & pht_r[pht_idx_s][1];
      if (taken_s) begin
         target_s = btb_target_r[btb_idx_s];
      end else begin
         target_s = bus.pc + 32'd4;
      end
   end

   assign bus.pred_hit    = hit_s;
   assign bus.pred_taken  = taken_s;
   assign bus.pred_target = target_s;
   assign bus.ready       = ready_r;

   // Next-state and table write controls (sweep writes or commit training).
   always_comb begin
      state_next_s  = state_r;
      pht_we_s      = 1'b0;
      pht_waddr_s   = '0;
      pht_wdata_s   = 2'b00;
      btb_we_s      = 1'b0;
      btb_waddr_s   = '0;
      btb_wvalid_s  = 1'b0;
      btb_wtag_s    = '0;
      btb_wtarget_s = 32'd0;
      case (state_r)
         ST_INIT: begin
            if (init_idx_r == INIT_BITS'(INIT_LAST)) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_INIT;
            end
            // The smaller table is only swept over its own depth.
            if (pht_init_range_s) begin
               pht_we_s    = 1'b1;
               pht_waddr_s = init_idx_r[PHT_IDX_BITS-1:0];
               pht_wdata_s = CTR_INIT;
            end else begin
               pht_we_s    = 1'b0;
            end
            if (btb_init_range_s) begin
               btb_we_s     = 1'b1;
               btb_waddr_s  = init_idx_r[BTB_IDX_BITS-1:0];
               btb_wvalid_s = 1'b0;
            end else begin
               btb_we_s     = 1'b0;
            end
         end
         ST_RUN: begin
            state_next_s = ST_RUN;
            if (bus.upd_valid) begin
               pht_we_s    = 1'b1;
               pht_waddr_s = upd_pht_idx_s;
               pht_wdata_s = ctr_step(pht_r[upd_pht_idx_s], bus.upd_taken);
               // Only taken branches allocate; this evicts any aliasing entry.
               if (bus.upd_taken) begin
                  btb_we_s      = 1'b1;
                  btb_waddr_s   = upd_btb_idx_s;
                  btb_wvalid_s  = 1'b1;
                  btb_wtag_s    = upd_tag_s;
                  btb_wtarget_s = bus.upd_target;
               end else begin
                  btb_we_s      = 1'b0;
               end
            end else begin
               pht_we_s = 1'b0;
            end
         end
         default: begin
            state_next_s = ST_INIT;
         end
      endcase
   end

   // Control registers: FSM state, sweep index, global history, ready flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_INIT;
         init_idx_r <= '0;
         ghr_r      <= '0;
         ready_r    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         ready_r <= (state_next_s == ST_RUN);
         if (state_r == ST_INIT) begin
            init_idx_r <= init_idx_r + INIT_BITS'(1);
         end else begin
            init_idx_r <= init_idx_r;
         end
         if ((state_r == ST_RUN) && bus.upd_valid) begin
            ghr_r <= ghr_next_s;
         end else begin
            ghr_r <= ghr_r;
         end
      end
   end

   // PHT write port; the pre-edge value is what predictions see this cycle.
   always_ff @(posedge clk) begin
      if (pht_we_s) begin
         pht_r[pht_waddr_s] <= pht_wdata_s;
      end
   end

   // BTB write port (valid, tag and target written as one entry).
   always_ff @(posedge clk) begin
      if (btb_we_s) begin
         btb_valid_r[btb_waddr_s]  <= btb_wvalid_s;
         btb_tag_r[btb_waddr_s]    <= btb_wtag_s;
         btb_target_r[btb_waddr_s] <= btb_wtarget_s;
      end
   end

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   branch_predictor_btb_if bus_a ();
   branch_predictor_btb_if bus_b ();

   // DUT A: bimodal, DUT B: gshare with 4 history bits.
   branch_predictor_btb #(.GHR_BITS(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   branch_predictor_btb #(.GHR_BITS(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   typedef struct {
      int          sel;
      logic        rdy;
      logic        hit;
      logic        tkn;
      logic [31:0] tgt;
   } exp_t;

   exp_t  exp_q  [$];
   string name_q [$];
   int    n_checks = 0;
   int    n_fail   = 0;
   event  probe_ev;

   // Monitor: pops expected responses and compares against the presented outputs.
   always begin
      @(probe_ev);
      while (exp_q.size() > 0) begin
         exp_t        e;
         string       nm;
         logic        a_rdy, a_hit, a_tkn;
         logic [31:0] a_tgt;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (e.sel == 0) begin
            a_rdy = bus_a.ready; a_hit = bus_a.pred_hit;
            a_tkn = bus_a.pred_taken; a_tgt = bus_a.pred_target;
         end else begin
            a_rdy = bus_b.ready; a_hit = bus_b.pred_hit;
            a_tkn = bus_b.pred_taken; a_tgt = bus_b.pred_target;
         end
         n_checks++;
         if ({a_rdy, a_hit, a_tkn, a_tgt} !== {e.rdy, e.hit, e.tkn, e.tgt}) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got ready=%b hit=%b taken=%b target=%h, expected ready=%b hit=%b taken=%b target=%h",
                     nm, e.sel, a_rdy, a_hit, a_tkn, a_tgt, e.rdy, e.hit, e.tkn, e.tgt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a pc, queue the hand-computed response, then let the monitor sample.
   task automatic probe(input int sel, input logic [31:0] pcv, input logic rdy,
                        input logic hit, input logic tkn, input logic [31:0] tgt,
                        input string nm);
      exp_t e;
      if (sel == 0) bus_a.pc = pcv;
      else          bus_b.pc = pcv;
      e.sel = sel; e.rdy = rdy; e.hit = hit; e.tkn = tkn; e.tgt = tgt;
      exp_q.push_back(e);
      name_q.push_back(nm);
      #1;
      ->probe_ev;
      #1;
   endtask

   // One-cycle update strobe on the selected DUT.
   task automatic upd(input int sel, input logic [31:0] upc, input logic t, input logic [31:0] utgt);
      if (sel == 0) begin
         bus_a.upd_pc = upc; bus_a.upd_taken = t; bus_a.upd_target = utgt; bus_a.upd_valid = 1'b1;
      end else begin
         bus_b.upd_pc = upc; bus_b.upd_taken = t; bus_b.upd_target = utgt; bus_b.upd_valid = 1'b1;
      end
      tick();
      bus_a.upd_valid = 1'b0;
      bus_b.upd_valid = 1'b0;
   endtask

   // Release reset and walk the 128-cycle sweep; ready must rise on edge 128 exactly.
   task automatic sweep(input logic [31:0] pcv, input string nm);
      rst = 1'b0;
      for (int i = 1; i <= 128; i++) begin
         tick();
         probe(0, pcv, (i == 128), 1'b0, 1'b0, pcv + 32'd4, nm);
         probe(1, pcv, (i == 128), 1'b0, 1'b0, pcv + 32'd4, nm);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_a.pc = 32'd0; bus_a.upd_valid = 1'b0; bus_a.upd_pc = 32'd0;
      bus_a.upd_taken = 1'b0; bus_a.upd_target = 32'd0;
      bus_b.pc = 32'd0; bus_b.upd_valid = 1'b0; bus_b.upd_pc = 32'd0;
      bus_b.upd_taken = 1'b0; bus_b.upd_target = 32'd0;
      repeat (3) tick();
      probe(0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h104, "reset_outputs");

      // Partial sweep, then reset at init_idx = 50.
      rst = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         tick();
         probe(0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h104, "sweep_partial");
      end
      rst = 1'b1;
      probe(0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h104, "rst_mid_sweep");
      tick();
      sweep(32'h100, "sweep_full");

      // Bimodal training: counter 1 -> 2 -> 3.
      upd(0, 32'h40, 1'b1, 32'h80);
      upd(0, 32'h40, 1'b1, 32'h80);
      probe(0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h80, "bimodal_train");

      // Saturation: stays 3 over five taken, then 2 (taken), then 1 (not taken).
      for (int i = 0; i < 5; i++) upd(0, 32'h40, 1'b1, 32'h80);
      upd(0, 32'h40, 1'b0, 32'h0);
      probe(0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h80, "sat_first_nt");
      upd(0, 32'h40, 1'b0, 32'h0);
      probe(0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h44, "sat_second_nt");

      // Tag alias: 0x140 shares BTB index 0x10 with 0x40 but has tag 1.
      upd(0, 32'h40, 1'b1, 32'h80);
      probe(0, 32'h40,  1'b1, 1'b1, 1'b1, 32'h80,  "alias_pre");
      probe(0, 32'h140, 1'b1, 1'b0, 1'b0, 32'h144, "alias_miss");
      tick();
      // Same-cycle read of the entry being written sees the old contents.
      bus_a.upd_pc = 32'h140; bus_a.upd_taken = 1'b1; bus_a.upd_target = 32'h200;
      bus_a.upd_valid = 1'b1;
      probe(0, 32'h140, 1'b1, 1'b0, 1'b0, 32'h144, "same_cycle_old");
      tick();
      bus_a.upd_valid = 1'b0;
      probe(0, 32'h140, 1'b1, 1'b1, 1'b1, 32'h200, "alias_new");
      probe(0, 32'h40,  1'b1, 1'b0, 1'b0, 32'h44,  "alias_evicted");
      probe(0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, "pc_wrap");
      tick();

      // Gshare: T,T,N,T leaves ghr = 4'b1101; PHT[0x1D] trained to 3 on the
      // two updates whose (pc index ^ ghr) landed on 0x1D.
      upd(1, 32'h74,  1'b1, 32'h300);   // idx 0x1D^0x0 = 0x1D : 1 -> 2
      upd(1, 32'h40,  1'b1, 32'h80);    // idx 0x10^0x1 = 0x11 : BTB[0x10] = 0x80
      upd(1, 32'h100, 1'b0, 32'h0);     // idx 0x40^0x3 = 0x43 : 1 -> 0
      upd(1, 32'h6C,  1'b1, 32'h400);   // idx 0x1B^0x6 = 0x1D : 2 -> 3
      probe(1, 32'h40, 1'b1, 1'b1, 1'b1, 32'h80, "gshare_idx_1d");
      probe(1, 32'h74, 1'b1, 1'b1, 1'b0, 32'h78, "gshare_idx_10");
      probe(1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h48, "gshare_miss");
      tick();

      // Reset in RUN: ready drops before the next edge, training is lost.
      rst = 1'b1;
      probe(0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h44, "rst_run_a");
      probe(1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h44, "rst_run_b");
      tick();
      sweep(32'h40, "sweep_after_run_rst");
      probe(0, 32'h40, 1'b1, 1'b0, 1'b0, 32'h44, "post_rst_a");
      probe(1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h44, "post_rst_b");
      tick();

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
